// File: rtl/core_pkg.sv
// Shared types and constants for the 15-bit core instruction sequencer.
// The BREAK state exists only when CORE_SEQUENCER_BREAKPOINT_EN is defined.
package core_pkg;

  localparam int unsigned INSTRUCTION_WIDTH = 15;

  // 1_0000_1011_00_00_00
  localparam logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR  = 15'h42C0;
  // Terminates a program; never presented to the core.
  localparam logic [INSTRUCTION_WIDTH-1:0] HALT_INSTR = 15'h7FFF;

  typedef enum logic [2:0] {
    StIdle,
    StHostIdle,
    StFetch,
    StIssue,
    StHostPause
`ifdef CORE_SEQUENCER_BREAKPOINT_EN
    ,
    StBreak
`endif
  } seq_state_e;

endpackage

// File: rtl/seq_issue_timer.sv
// Loadable down-counter that times how long an instruction is held on the core port.
// expire is high while the count is zero.
module seq_issue_timer #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             expire
);

  logic [Width-1:0] count_q, count_d;

  // Load takes priority; otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - Width'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == '0);

endmodule

// File: rtl/core_sequencer.sv
// Instruction sequencer: fetches from a synchronous ROM, holds each instruction on the core
// port for ISSUE_CYCLES clocks and hands the core memory port to a host loader only at
// instruction boundaries. Defining CORE_SEQUENCER_BREAKPOINT_EN adds an address breakpoint.
module core_sequencer
  import core_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = 8,
  parameter int unsigned ISSUE_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [PC_WIDTH-1:0]          start_pc,
  output logic [PC_WIDTH-1:0]          imem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_data,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  input  logic                         host_req,
  output logic                         host_gnt,
  output logic                         cpen,
  output logic [PC_WIDTH-1:0]          pc,
  output logic                         busy,
  output logic                         done
`ifdef CORE_SEQUENCER_BREAKPOINT_EN
  ,
  input  logic [PC_WIDTH-1:0]          bp_addr,
  input  logic                         bp_enable,
  output logic                         bp_hit,
  input  logic                         resume
`endif
);

  localparam int unsigned TimerW = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES) : 1;

  seq_state_e                   state_q, state_d;
  logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]          addr_q, addr_d;
  logic [PC_WIDTH-1:0]          pc_q, pc_d;
  logic                         gnt_q, gnt_d;
  logic                         timer_load;
  logic                         timer_expire;
`ifdef CORE_SEQUENCER_BREAKPOINT_EN
  logic                         bp_skip_q, bp_skip_d;
`endif

  seq_issue_timer #(
    .Width(TimerW)
  ) u_issue_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .load_val(TimerW'(ISSUE_CYCLES - 1)),
    .expire  (timer_expire)
  );

  // Next-state, datapath updates and the Mealy done pulse.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    addr_d     = addr_q;
    pc_d       = pc_q;
    gnt_d      = gnt_q;
    timer_load = 1'b0;
    done       = 1'b0;
`ifdef CORE_SEQUENCER_BREAKPOINT_EN
    bp_skip_d  = bp_skip_q;
`endif
    unique case (state_q)
      StIdle: begin
        // Host wins over a simultaneous start.
        if (host_req) begin
          gnt_d   = 1'b1;
          state_d = StHostIdle;
        end else if (start) begin
          addr_d  = start_pc;
          state_d = StFetch;
        end
      end
      StHostIdle: begin
        if (!host_req) begin
          gnt_d   = 1'b0;
          state_d = StIdle;
        end
      end
      StFetch: begin
`ifdef CORE_SEQUENCER_BREAKPOINT_EN
        bp_skip_d = 1'b0;
        if (bp_enable && (addr_q == bp_addr) && !bp_skip_q) begin
          instr_d = NOP_INSTR;
          state_d = StBreak;
        end else
`endif
        if (imem_data == HALT_INSTR) begin
          done    = 1'b1;
          instr_d = NOP_INSTR;
          state_d = StIdle;
        end else begin
          instr_d    = imem_data;
          pc_d       = addr_q;
          timer_load = 1'b1;
          addr_d     = addr_q + PC_WIDTH'(1);
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (timer_expire) begin
          if (host_req) begin
            instr_d = NOP_INSTR;
            gnt_d   = 1'b1;
            state_d = StHostPause;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StHostPause: begin
        if (!host_req) begin
          gnt_d   = 1'b0;
          state_d = StFetch;
        end
      end
`ifdef CORE_SEQUENCER_BREAKPOINT_EN
      StBreak: begin
        // Resume is honoured only while the host does not own the port.
        if (gnt_q) begin
          if (!host_req) gnt_d = 1'b0;
        end else if (host_req) begin
          gnt_d = 1'b1;
        end else if (resume) begin
          bp_skip_d = 1'b1;
          state_d   = StFetch;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      instr_q <= NOP_INSTR;
      addr_q  <= '0;
      pc_q    <= '0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      gnt_q   <= gnt_d;
    end
  end

`ifdef CORE_SEQUENCER_BREAKPOINT_EN
  // One-shot breakpoint suppression for the fetch right after resume.
  always_ff @(posedge clk) begin
    if (reset) begin
      bp_skip_q <= 1'b0;
    end else begin
      bp_skip_q <= bp_skip_d;
    end
  end

  assign bp_hit = (state_q == StBreak);
`endif

  // The ROM captures the next address on the same edge the FSM moves, so its data is
  // ready during the following FETCH cycle.
  assign imem_addr   = reset ? '0 : addr_d;
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign host_gnt    = gnt_q;
  assign cpen        = gnt_q;
`ifdef CORE_SEQUENCER_BREAKPOINT_EN
  assign busy = (state_q == StFetch) || (state_q == StIssue) || (state_q == StHostPause) ||
                (state_q == StBreak);
`else
  assign busy = (state_q == StFetch) || (state_q == StIssue) || (state_q == StHostPause);
`endif

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Instruction sequencer for the 15-bit core.
- Fetches instructions from a synchronous instruction ROM and presents each one to the core's instruction port for a fixed number of clocks; presents NOP between and after programs.
- Shares the core's memory port with a host loader through a req/gnt handshake. The host is granted only at instruction boundaries.
- Sits between the top level, the instruction ROM and the core.

Parameters:
- INSTRUCTION_WIDTH, 15, core instruction width.
- PC_WIDTH, 8, program counter / ROM address width.
- ISSUE_CYCLES, 2, clocks each instruction is held on the core port (must be >= 1).
- NOP_INSTR, 15'h42C0, encoding of the core NOP (1_0000_1011_00_00_00).
- HALT_INSTR, 15'h7FFF, encoding that ends a program; it is never issued to the core.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse: begin execution at start_pc.
- start_pc  in  PC_WIDTH  program entry address.
- imem_addr  out  PC_WIDTH  instruction ROM address.
- imem_data  in  INSTRUCTION_WIDTH  ROM data, valid 1 clk after imem_addr.
- instruction  out  INSTRUCTION_WIDTH  to core instruction port.
- host_req  in  1  host wants the core memory port.
- host_gnt  out  1  host owns the core memory port.
- cpen  out  1  core port enable toward the core; equals host_gnt.
- pc  out  PC_WIDTH  address of the instruction currently issued.
- busy  out  1  program running (FETCH/ISSUE/HOST_PAUSE).
- done  out  1  one-clock pulse when HALT is reached.

Behaviour:
- Reset values: instruction=NOP_INSTR, imem_addr=0, pc=0, host_gnt=0, cpen=0, busy=0, done=0, state=IDLE.
- Reset asserted mid-program aborts immediately and gives the same values; an outstanding grant is dropped.

States:
- IDLE:
  - instruction=NOP.
  - If host_req=1: host_gnt=1 next clk (HOST_IDLE).
  - Else if start=1: latch start_pc into imem_addr -> FETCH.
  - If start and host_req arrive in the same clk, host wins and start is dropped.
- HOST_IDLE:
  - host_gnt=1, instruction=NOP.
  - When host_req=0: host_gnt=0 next clk -> IDLE.
- FETCH (1 clk, ROM latency):
  - If imem_data==HALT_INSTR: done=1 for one clk -> IDLE, busy=0.
  - Else: instruction<=imem_data, pc<=imem_addr, issue counter<=ISSUE_CYCLES-1, imem_addr<=imem_addr+1 -> ISSUE.
- ISSUE:
  - Instruction held. Counter decrements each clk.
  - At 0, if host_req=1: instruction<=NOP, host_gnt<=1 -> HOST_PAUSE.
  - At 0, otherwise -> FETCH.
- HOST_PAUSE:
  - host_gnt=1, instruction=NOP, busy=1, pc frozen.
  - host_req=0 -> host_gnt=0 -> FETCH (resume at imem_addr).

Timing and arithmetic:
- Issue period per instruction = 1 (FETCH) + ISSUE_CYCLES clocks.
- While in FETCH, instruction keeps showing the previous instruction. The first FETCH after start shows NOP.
- PC arithmetic is modulo 2^PC_WIDTH: 0xFF+1 wraps to 0x00, with no flag.
- start while busy is ignored.
- host_req dropping before grant (never granted) has no effect.
- host_gnt never toggles mid-instruction.

Optional Feature:
- Macro: CORE_SEQUENCER_BREAKPOINT_EN.
- When defined:
  - Extra ports: bp_addr (in, PC_WIDTH), bp_enable (in, 1), bp_hit (out, 1), resume (in, 1).
  - In FETCH, if bp_enable=1 and imem_addr==bp_addr, the instruction is not issued. Go to BREAK: instruction=NOP, bp_hit=1, busy=1.
  - resume pulse re-enters FETCH with the match suppressed for that one fetch.
  - host_req is granted while in BREAK, the same way as in HOST_PAUSE.
- When undefined: no extra ports and no BREAK state; behaviour as above.

Decomposition:
- Package core_pkg:
  - INSTRUCTION_WIDTH
  - NOP_INSTR, HALT_INSTR
  - state enum (IDLE, HOST_IDLE, FETCH, ISSUE, HOST_PAUSE, BREAK)
- One sub-module: seq_issue_timer. It is the loadable down-counter for ISSUE_CYCLES, with load/expire. Everything else is in core_sequencer.

Test Plan:
- Reset during ISSUE with host_req=0 -> next clk: instruction=15'h42C0, pc=0, busy=0, host_gnt=0.
- ROM[0..4]={movl r0 0 (15'h1400), load, mov, add, HALT}, start_pc=0 -> four instructions, each held exactly 2 clks with 1-clk FETCH gaps; pc=0,1,2,3; done pulses once at 12 clks after start; no HALT on the instruction port.
- host_req raised mid-ISSUE of pc=1 -> grant only after pc=1's hold ends; NOP during grant; after release, pc=2 issues; instruction count is unchanged.
- host_req and start in the same clk in IDLE -> host_gnt=1, start ignored, busy=0; after release, busy stays 0.
- start_pc=0xFE, ROM[0xFE]=add, ROM[0xFF]=store, ROM[0x00]=HALT -> pc sequence 0xFE, 0xFF, then done with imem_addr wrapped to 0x00.
- With CORE_SEQUENCER_BREAKPOINT_EN defined, bp_addr=2, bp_enable=1 -> bp_hit=1 before pc 2 issues, NOP held; resume -> pc=2 issues, followed by normal completion.
